psum_xchg_hub: RTL
==================

PSUM_XCHG_HUB -- requirements
Module: psum_xchg_hub

Interface
REQ-001 Parameter NCORE, default 2: number of cores attached; SHALL be >=2.
REQ-002 Parameter BW, default 24: partial-sum word width, signed two's complement.
REQ-003 Parameter DEPTH, default 16: entries per source FIFO; SHALL be a power of two >=2.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high.
REQ-006 mode  input  2: 0 RING, 1 LOOPBACK, 2 REDUCE, 3 HOLD.
REQ-007 wr  input  NCORE: push request, bit i = core i.
REQ-008 din  input  NCORE*BW: push data, slice i = core i.
REQ-009 rd  input  NCORE: pop request, bit i = core i.
REQ-010 dout  output  NCORE*BW: registered read data, slice i = core i.
REQ-011 dout_valid  output  NCORE: one-cycle pulse marking new dout slice i.
REQ-012 full  output  NCORE: source FIFO i holds DEPTH entries.
REQ-013 empty  output  NCORE: source FIFO i holds 0 entries.
REQ-014 ovf  output  1: sticky overflow error.
REQ-015 udf  output  1: sticky underflow error.

Function
REQ-016 One FIFO per source core i; written only by core i; occupancy counter 0..DEPTH; pointers wrap modulo DEPTH.
REQ-017 full/empty SHALL be derived from the occupancy register (state at cycle start, not next state).
REQ-018 Push: wr[i]=1 and full[i]=0 stores din slice i; wr[i]=1 and full[i]=1 drops the word and sets ovf, even with a concurrent pop of FIFO i.
REQ-019 Simultaneous accepted push and pop on the same FIFO SHALL leave occupancy unchanged; pop returns the old head.
REQ-020 RING: core i reads head of FIFO (i+1) mod NCORE; NCORE=2 gives pairwise swap.
REQ-021 LOOPBACK: core i reads head of its own FIFO i.
REQ-022 RING/LOOPBACK: rd[i]=1 with source FIFO non-empty pops it; dout slice i <= head and dout_valid[i]=1 on the next cycle (latency 1).
REQ-023 RING/LOOPBACK: rd[i]=1 with source FIFO empty is ignored, sets udf; dout slice i holds, dout_valid[i]=0.
REQ-024 RING: if pops target distinct FIFOs they SHALL all complete in the same cycle.
REQ-025 REDUCE: rd[0] is the sole trigger; rd[NCORE-1:1] ignored.
REQ-026 REDUCE: rd[0]=1 and all FIFOs non-empty pops every FIFO once; the signed sum of all heads, saturated to BW bits (max 2^(BW-1)-1, min -2^(BW-1)), goes to every dout slice; all dout_valid bits =1 next cycle.
REQ-027 REDUCE: rd[0]=1 with any FIFO empty pops nothing, sets udf, all dout hold.
REQ-028 Sum SHALL be computed at width BW+clog2(NCORE) before saturation.
REQ-029 HOLD: all rd ignored, no pops, no udf; pushes still accepted.
REQ-030 mode is sampled every cycle; a change affects that cycle's pop decision; no internal mode state.
REQ-031 dout_valid SHALL be 0 in every cycle not following an accepted pop for that slice.
REQ-032 ovf/udf SHALL stay set until reset.

Reset
REQ-033 reset=1 SHALL immediately clear all occupancy counters and pointers, dout to 0, dout_valid to 0, ovf/udf to 0; full=0, empty=all ones.
REQ-034 Reset mid-operation SHALL discard all FIFO contents; first push after release lands at entry 0.
REQ-035 While reset=1, wr and rd SHALL have no effect.

Verification (NCORE=2, BW=24, DEPTH=16)
REQ-036 RING swap: core0 pushes 5, core1 pushes 7; mode=0, rd=2'b11 -> next cycle dout0=7, dout1=5, dout_valid=2'b11.
REQ-037 Full/overflow: 17 pushes 1..17 into core0 -> full[0]=1 after 16th, 17 dropped, ovf=1; 16 LOOPBACK pops return 1..16 in order, then empty[0]=1.
REQ-038 Underflow: mode=1, rd[1]=1 with FIFO1 empty -> udf=1, dout_valid[1]=0, dout1 unchanged.
REQ-039 REDUCE saturation: push 0x7FFFF0 and 0x000020, mode=2, rd[0]=1 -> dout0=dout1=0x7FFFFF, both valid; with FIFO1 empty, rd[0]=1 -> udf=1, FIFO0 occupancy unchanged.
REQ-040 Concurrent push/pop at full: FIFO0 full, wr[0]=1 and LOOPBACK rd[0]=1 same cycle -> pop succeeds, push dropped, ovf=1, occupancy 15.
REQ-041 Reset mid-stream: 3 entries queued, assert reset asynchronously between edges -> empty=2'b11, dout=0, ovf=udf=0 immediately; push 9 after release, pop -> 9.

Source files
------------

// File: rtl/psum_xchg_hub.sv
// Partial-sum exchange hub: one FIFO per source core, read back by ring, loopback
// or saturating all-core reduce, with sticky overflow/underflow flags.
module psum_xchg_hub #(
    parameter int unsigned NCORE = 2,
    parameter int unsigned BW    = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [NCORE-1:0]    wr,
    input  logic [NCORE*BW-1:0] din,
    input  logic [NCORE-1:0]    rd,
    output logic [NCORE*BW-1:0] dout,
    output logic [NCORE-1:0]    dout_valid,
    output logic [NCORE-1:0]    full,
    output logic [NCORE-1:0]    empty,
    output logic                ovf,
    output logic                udf
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = BW + $clog2(NCORE);

    typedef enum logic [1:0] {
        ModeRing   = 2'd0,
        ModeLoop   = 2'd1,
        ModeReduce = 2'd2,
        ModeHold   = 2'd3
    } mode_e;

    logic [BW-1:0] mem [NCORE][DEPTH];
    logic [AW-1:0] wptr_q [NCORE];
    logic [AW-1:0] rptr_q [NCORE];
    logic [CW-1:0] cnt_q [NCORE];
    logic [BW-1:0] head [NCORE];

    logic [NCORE-1:0]    push, pop, rd_ok;
    logic [NCORE*BW-1:0] dout_d, dout_q;
    logic [NCORE-1:0]    dv_q;
    logic                ovf_set, udf_set, ovf_q, udf_q;
    logic signed [SW-1:0] sum;
    logic [BW-1:0]       sum_sat;

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

    always_comb begin
        for (int i = 0; i < NCORE; i++) begin
            full[i]  = (cnt_q[i] == CW'(DEPTH));
            empty[i] = (cnt_q[i] == '0);
            head[i]  = mem[i][rptr_q[i]];
        end
    end

    // Full word drops even if the same FIFO is popped this cycle.
    always_comb begin
        push    = wr & ~full;
        ovf_set = |(wr & full);
    end

    // Wide accumulate, then clamp when the guard bits disagree with the sign.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NCORE; i++) begin
            sum = sum + SW'($signed(head[i]));
        end
        if (sum[SW-1:BW-1] == '0 || sum[SW-1:BW-1] == '1) begin
            sum_sat = sum[BW-1:0];
        end else if (sum[SW-1]) begin
            sum_sat = {1'b1, {(BW-1){1'b0}}};
        end else begin
            sum_sat = {1'b0, {(BW-1){1'b1}}};
        end
    end

    always_comb begin
        int unsigned src;
        src     = 0;
        pop     = '0;
        rd_ok   = '0;
        udf_set = 1'b0;
        dout_d  = dout_q;
        case (mode_e'(mode))
            ModeRing, ModeLoop: begin
                for (int unsigned i = 0; i < NCORE; i++) begin
                    src = (mode_e'(mode) == ModeRing) ? (i + 1) % NCORE : i;
                    if (rd[i]) begin
                        if (empty[src]) begin
                            udf_set = 1'b1;
                        end else begin
                            pop[src]             = 1'b1;
                            rd_ok[i]             = 1'b1;
                            dout_d[i*BW +: BW]   = head[src];
                        end
                    end
                end
            end
            ModeReduce: begin
                if (rd[0]) begin
                    if (|empty) begin
                        udf_set = 1'b1;
                    end else begin
                        pop   = '1;
                        rd_ok = '1;
                        for (int i = 0; i < NCORE; i++) begin
                            dout_d[i*BW +: BW] = sum_sat;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCORE; i++) begin
            if (push[i] && !reset) begin
                mem[i][wptr_q[i]] <= din[i*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCORE; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            dout_q <= '0;
            dv_q   <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NCORE; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
                if (pop[i])  rptr_q[i] <= rptr_q[i] + AW'(1);
                if (push[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (!push[i] && pop[i]) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
            dout_q <= dout_d;
            dv_q   <= rd_ok;
            ovf_q  <= ovf_q | ovf_set;
            udf_q  <= udf_q | udf_set;
        end
    end

endmodule
